sub_bytes_engine: RTL and testbench

Parametrised, handshaked AES SubBytes unit that performs either the forward or the inverse byte substitution on a 128-bit state. It replaces the purely combinational 16-lookup inverse stage. A generic LANES parameter trades area (number of S-box instances) against latency (16/LANES passes). It sits between the round-key/ShiftRows stages of the encrypt and decrypt datapaths and is shared by both through a per-transaction mode bit.

---
 rtl/sub_bytes_engine.sv | 140 ++++++++++++++
 tb/tb_sub_bytes_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// AES SubBytes engine: forward or inverse byte substitution of a 128-bit state,
// LANES bytes per cycle over 16/LANES passes, with valid/ready on both sides.
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_inv,
  output logic [127:0] out_state
);

  localparam int PASSES = 16 / LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       src_q, src_d;
  logic [127:0]       res_q, res_d;
  logic               mode_q, mode_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  function automatic logic [7:0] sbox_lookup(input logic inv, input logic [7:0] b);
    return inv ? INV_SBOX[b] : FWD_SBOX[b];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          src_d   = in_state;
          mode_d  = in_inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Bytes cnt*LANES .. cnt*LANES+LANES-1, lowest index first across passes.
        for (int l = 0; l < LANES; l++) begin
          res_d[(int'(cnt_q) * LANES + l) * 8 +: 8] =
            sbox_lookup(mode_q, src_q[(int'(cnt_q) * LANES + l) * 8 +: 8]);
        end
        if (cnt_q == CNT_W'(PASSES - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      res_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      res_q       <= res_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inv   = mode_q;
  assign out_state = res_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: one instance per legal LANES value, directed
// table vectors, a GF(2^8)-derived reference for round trips, and corner sequences.
module tb_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [5];
  logic         in_inv    [5];
  logic [127:0] in_state  [5];
  logic         out_ready [5];
  logic         in_ready_w  [5];
  logic         out_valid_w [5];
  logic         out_inv_w   [5];
  logic [127:0] out_state_w [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready_w[g]),
      .in_inv    (in_inv[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready[g]),
      .out_inv   (out_inv_w[g]),
      .out_state (out_state_w[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S(x) = affine(x^254) over GF(2^8) with the AES polynomial.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    if (x == 8'h00) r = 8'h00;
    else for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_ref(input logic inv, input logic [127:0] st);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[i*8 +: 8] = inv ? inv_t[st[i*8 +: 8]] : fwd_t[st[i*8 +: 8]];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_result(input int k, output logic [127:0] res, output logic rinv, output int lat);
    lat = 0;
    while (!out_valid_w[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = out_state_w[k];
    rinv = out_inv_w[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic run_txn(input int k, input logic inv, input logic [127:0] st,
                         output logic [127:0] res, output logic rinv, output int lat);
    @(posedge clk); #1;
    in_valid[k] = 1'b1;
    in_inv[k]   = inv;
    in_state[k] = st;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_inv[k]   = ~inv;
    in_state[k] = {$urandom, $urandom, $urandom, $urandom};
    wait_result(k, res, rinv, lat);
  endtask

  typedef struct {
    logic         inv;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] r1, r2, sta, stb;
    logic         ri;
    int           lat;
    logic         saw_valid;

    vecs[0] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[1] = '{1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    vecs[2] = '{1'b0, {16{8'h00}}, {16{8'h63}}};
    vecs[3] = '{1'b1, {16{8'h00}}, {16{8'h52}}};
    vecs[4] = '{1'b1, {16{8'hff}}, {16{8'h7d}}};
    vecs[5] = '{1'b0, {16{8'h53}}, {16{8'hed}}};

    for (int x = 0; x < 256; x++) fwd_t[x] = sbox_ref(8'(x));
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

    for (int k = 0; k < 5; k++) begin
      in_valid[k] = 1'b0; in_inv[k] = 1'b0; in_state[k] = '0; out_ready[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst_in_ready_l%0d", 1 << k), 128'(in_ready_w[k]), 128'd1);
      chk($sformatf("rst_out_valid_l%0d", 1 << k), 128'(out_valid_w[k]), 128'd0);
      chk($sformatf("rst_out_inv_l%0d", 1 << k), 128'(out_inv_w[k]), 128'd0);
      chk($sformatf("rst_out_state_l%0d", 1 << k), out_state_w[k], 128'd0);
    end

    for (int k = 0; k < 5; k++) begin
      for (int v = 0; v < 6; v++) begin
        run_txn(k, vecs[v].inv, vecs[v].st, r1, ri, lat);
        chk($sformatf("vec%0d_state_l%0d", v, 1 << k), r1, vecs[v].exp);
        chk($sformatf("vec%0d_inv_l%0d", v, 1 << k), 128'(ri), 128'(vecs[v].inv));
        chk($sformatf("vec%0d_lat_l%0d", v, 1 << k), 128'(lat), 128'(16 >> k));
      end
    end

    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 256; b++) begin
        sta = {16{8'(b)}};
        run_txn(k, 1'b0, sta, r1, ri, lat);
        chk($sformatf("rt_fwd_%02h_l%0d", b, 1 << k), r1, sub_ref(1'b0, sta));
        run_txn(k, 1'b1, r1, r2, ri, lat);
        chk($sformatf("rt_inv_%02h_l%0d", b, 1 << k), r2, sta);
      end
    end

    // Backpressure with a queued source, LANES=4.
    sta = 128'h00112233445566778899aabbccddeeff;
    stb = 128'h0123456789abcdeffedcba9876543210;
    @(posedge clk); #1;
    in_valid[2] = 1'b1; in_inv[2] = 1'b0; in_state[2] = sta;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    lat = 0;
    while (!out_valid_w[2] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 128'(lat), 128'd4);
    in_valid[2] = 1'b1; in_inv[2] = 1'b1; in_state[2] = stb;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_state_c%0d", c), out_state_w[2], sub_ref(1'b0, sta));
      chk($sformatf("bp_in_ready_c%0d", c), 128'(in_ready_w[2]), 128'd0);
      chk($sformatf("bp_out_valid_c%0d", c), 128'(out_valid_w[2]), 128'd1);
    end
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    out_ready[2] = 1'b0;
    chk("bp_release_out_valid", 128'(out_valid_w[2]), 128'd0);
    chk("bp_release_in_ready", 128'(in_ready_w[2]), 128'd1);
    @(posedge clk); #1;
    chk("bp_queued_accepted", 128'(in_ready_w[2]), 128'd0);
    in_valid[2] = 1'b0;
    wait_result(2, r1, ri, lat);
    chk("bp_queued_state", r1, sub_ref(1'b1, stb));
    chk("bp_queued_inv", 128'(ri), 128'd1);
    chk("bp_queued_lat", 128'(lat), 128'd4);

    // Reset during pass 7 of a LANES=1 transaction.
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_inv[0] = 1'b0; in_state[0] = sta;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 128'(in_ready_w[0]), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid_w[0]), 128'd0);
    chk("mid_rst_out_state", out_state_w[0], 128'd0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid_w[0]) saw_valid = 1'b1;
    end
    chk("mid_rst_no_result", 128'(saw_valid), 128'd0);
    run_txn(0, 1'b1, stb, r1, ri, lat);
    chk("post_rst_state", r1, sub_ref(1'b1, stb));
    chk("post_rst_inv", 128'(ri), 128'd1);
    chk("post_rst_lat", 128'(lat), 128'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
